// File: rtl/rec_mvd_rot_ctrl_pkg.sv
// Shared constants and FSM encoding for the rotating MVD store sequencer.
package rec_mvd_rot_ctrl_pkg;
  localparam int MVD_WIDTH   = 10;
  localparam int MVD_ENTRY_W = 2 * MVD_WIDTH + 1;
  localparam int MVD_DEPTH   = 64;
  localparam int MVD_ADR_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_ROT    = 3'd3,
    ST_DONE   = 3'd4
  } rot_state_e;
endpackage

// File: rtl/rec_mvd_rd_sweep.sv
// Slot-2 read sweep: gapless 0..MVD_DEPTH-1 address walk under stall, with
// data-valid/last aligned to the store's 1-cycle read latency.
module rec_mvd_rd_sweep
  import rec_mvd_rot_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 stall_i,
  output logic                 rd_ena_o,
  output logic [MVD_ADR_W-1:0] rd_adr_o,
  output logic                 rd_dat_vld_o,
  output logic                 rd_last_o
);
  logic                 act_q, act_d;
  logic [MVD_ADR_W-1:0] adr_q, adr_d;
  logic                 vld_q, last_q;
  logic                 at_end;

  assign at_end   = (adr_q == MVD_ADR_W'(MVD_DEPTH - 1));
  assign rd_ena_o = act_q & ~stall_i;

  always_comb begin
    act_d = act_q;
    adr_d = adr_q;
    if (start_i) begin
      act_d = 1'b1;
      adr_d = '0;
    end else if (rd_ena_o) begin
      adr_d = adr_q + MVD_ADR_W'(1);
      if (at_end) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q  <= 1'b0;
      adr_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      adr_q  <= adr_d;
      vld_q  <= rd_ena_o;
      last_q <= rd_ena_o & at_end;
    end
  end

  assign rd_adr_o     = adr_q;
  assign rd_dat_vld_o = vld_q;
  assign rd_last_o    = last_q;
endmodule

// File: rtl/rec_mvd_rot_ctrl.sv
// Sequencer for the 3-slot rotating MVD store: launches producer writes into
// slot 0, sweeps slot 2 for the consumer, and rotates once both sides finish.
module rec_mvd_rot_ctrl
  import rec_mvd_rot_ctrl_pkg::*;
#(
  parameter int LCU_NUM_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [LCU_NUM_W-1:0] lcu_num_i,
  output logic                 wr_start_o,
  input  logic                 wr_done_i,
  output logic                 rotate_o,
  input  logic                 rd_stall_i,
  output logic                 rd_ena_o,
  output logic [MVD_ADR_W-1:0] rd_adr_o,
  output logic                 rd_dat_vld_o,
  output logic                 rd_last_o,
  output logic                 busy_o,
  output logic                 done_o
);
  rot_state_e           state_q, state_d;
  logic [LCU_NUM_W-1:0] lcu_num_q, lcu_num_d;
  logic [LCU_NUM_W-1:0] iss_cnt_q, iss_cnt_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic                 wr_act_q, wr_act_d, rd_act_q, rd_act_d;
  logic                 wr_seen_q, wr_seen_d, rd_seen_q, rd_seen_d;
  logic                 zdone_q, zdone_d;
  logic                 wr_act_now, sweep_start;

  assign wr_act_now = (iss_cnt_q < lcu_num_q);

  always_comb begin
    state_d     = state_q;
    lcu_num_d   = lcu_num_q;
    iss_cnt_d   = iss_cnt_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    wr_act_d    = wr_act_q;
    rd_act_d    = rd_act_q;
    wr_seen_d   = wr_seen_q;
    rd_seen_d   = rd_seen_q;
    zdone_d     = 1'b0;
    wr_start_o  = 1'b0;
    rotate_o    = 1'b0;
    sweep_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lcu_num_d = lcu_num_i;
          iss_cnt_d = '0;
          v1_d      = 1'b0;
          v2_d      = 1'b0;
          wr_seen_d = 1'b0;
          rd_seen_d = 1'b0;
          if (lcu_num_i == '0) zdone_d = 1'b1;
          else                 state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wr_act_d    = wr_act_now;
        rd_act_d    = v2_q;
        wr_start_o  = wr_act_now;
        iss_cnt_d   = iss_cnt_q + LCU_NUM_W'(wr_act_now);
        sweep_start = v2_q;
        // An inactive side counts as already finished.
        wr_seen_d   = ~wr_act_now;
        rd_seen_d   = ~v2_q;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        wr_seen_d = wr_seen_q | (wr_done_i & wr_act_q);
        rd_seen_d = rd_seen_q | rd_last_o;
        if (wr_seen_d && rd_seen_d) state_d = ST_ROT;
      end
      ST_ROT: begin
        rotate_o = 1'b1;
        v2_d     = v1_q;
        v1_d     = wr_act_q;
        if ((iss_cnt_q == lcu_num_q) && !wr_act_q && !v1_q) state_d = ST_DONE;
        else                                                 state_d = ST_LAUNCH;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      lcu_num_q <= '0;
      iss_cnt_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      wr_seen_q <= 1'b0;
      rd_seen_q <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcu_num_q <= lcu_num_d;
      iss_cnt_q <= iss_cnt_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      wr_act_q  <= wr_act_d;
      rd_act_q  <= rd_act_d;
      wr_seen_q <= wr_seen_d;
      rd_seen_q <= rd_seen_d;
      zdone_q   <= zdone_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE) | zdone_q;

  rec_mvd_rd_sweep u_sweep (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (sweep_start),
    .stall_i     (rd_stall_i),
    .rd_ena_o    (rd_ena_o),
    .rd_adr_o    (rd_adr_o),
    .rd_dat_vld_o(rd_dat_vld_o),
    .rd_last_o   (rd_last_o)
  );
endmodule

// File: tb/tb_rec_mvd_rot_ctrl.sv
// Scoreboard bench: behavioural 3-slot store + producer model, expected
// per-LCU tagged sweeps queued at run start and popped by a monitor.
module tb_rec_mvd_rot_ctrl;
  import rec_mvd_rot_ctrl_pkg::*;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] lcu_num_i = '0;
  logic          wr_done_i = 1'b0;
  logic          rd_stall_i = 1'b0;
  logic          wr_start_o, rotate_o, rd_ena_o, rd_dat_vld_o, rd_last_o, busy_o, done_o;
  logic [5:0]    rd_adr_o;

  always #5 clk = ~clk;

  rec_mvd_rot_ctrl #(.LCU_NUM_W(LW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .lcu_num_i(lcu_num_i),
    .wr_start_o(wr_start_o), .wr_done_i(wr_done_i), .rotate_o(rotate_o),
    .rd_stall_i(rd_stall_i), .rd_ena_o(rd_ena_o), .rd_adr_o(rd_adr_o),
    .rd_dat_vld_o(rd_dat_vld_o), .rd_last_o(rd_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural store: logical slot s lives in physical (s - rotations) mod 3.
  logic [31:0] mem [3][64];
  logic [31:0] rd_q;
  int rot_tot = 0;
  function automatic int phys(input int s);
    return (s + 3 - (rot_tot % 3)) % 3;
  endfunction
  always @(posedge clk) if (rd_ena_o) rd_q <= mem[phys(2)][rd_adr_o];

  logic [31:0] exp_q[$];
  int cnt_rot, cnt_wrs, cnt_vld, cnt_last, cnt_rdena, cnt_busy, first_vld_rot;
  int run_id = 0, wr_idx = 0, wr_delay = 5;
  bit follow_chk = 0, stall_en = 0;

  // Monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (rotate_o) begin
        cnt_rot++;
        rot_tot++;
        chk_eq("rotate_with_vld", rd_dat_vld_o, 0);
      end
      if (rd_ena_o) cnt_rdena++;
      if (rd_last_o) cnt_last++;
      if (busy_o) cnt_busy++;
      if (rd_dat_vld_o) begin
        if (cnt_vld == 0) first_vld_rot = cnt_rot;
        cnt_vld++;
        if (exp_q.size() == 0) chk_eq("unexpected_vld", 1, 0);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk_eq("rd_data", rd_q, e);
          chk_eq("rd_last", rd_last_o, (e[15:0] == 16'd63));
        end
      end
    end
  end

  // Producer: fills slot 0 on wr_start, reports done after wr_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && wr_start_o) begin
        int p;
        logic [15:0] tag;
        cnt_wrs++;
        tag = 16'(run_id * 256 + wr_idx);
        wr_idx++;
        p = phys(0);
        for (int a = 0; a < 64; a++) mem[p][a] = {tag, 16'(a)};
        repeat (wr_delay) @(posedge clk);
        #1 wr_done_i = 1'b1;
        @(posedge clk);
        #1 wr_done_i = 1'b0;
        if (follow_chk) begin
          @(negedge clk);
          chk_eq("rotate_after_wr_done", rotate_o, 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rd_stall_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic start_run(input int n, input bit stall, input int dly, input bit fol);
    cnt_rot = 0; cnt_wrs = 0; cnt_vld = 0; cnt_last = 0; cnt_rdena = 0; cnt_busy = 0;
    first_vld_rot = -1;
    run_id++; wr_idx = 0;
    stall_en = stall; wr_delay = dly; follow_chk = fol;
    for (int j = 0; j < n; j++)
      for (int a = 0; a < 64; a++) exp_q.push_back({16'(run_id * 256 + j), 16'(a)});
    @(posedge clk);
    #1 start_i = 1'b1; lcu_num_i = LW'(n);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic do_run(input int n, input bit stall, input int dly, input bit fol);
    int budget, c_done;
    bit got;
    start_run(n, stall, dly, fol);
    budget = n * (dly + 150) + 400;
    got = 0; c_done = -1;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (done_o) begin got = 1; c_done = c; end
    end
    chk_eq("done_seen", got, 1);
    if (n == 0) begin
      chk_eq("zero_done_latency", c_done, 0);
      chk_eq("zero_rotations", cnt_rot, 0);
      chk_eq("zero_rd_ena", cnt_rdena, 0);
      chk_eq("zero_busy", cnt_busy, 0);
    end else begin
      chk_eq("rotations", cnt_rot, n + 2);
      chk_eq("first_sweep_after_rot", first_vld_rot, 2);
    end
    chk_eq("wr_starts", cnt_wrs, n);
    chk_eq("rd_last_count", cnt_last, n);
    chk_eq("vld_count", cnt_vld, 64 * n);
    chk_eq("queue_empty", exp_q.size(), 0);
    stall_en = 0; follow_chk = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_rotate"}, rotate_o, 0);
    chk_eq({tag, "_wr_start"}, wr_start_o, 0);
    chk_eq({tag, "_rd_ena"}, rd_ena_o, 0);
    chk_eq({tag, "_rd_adr"}, rd_adr_o, 0);
    chk_eq({tag, "_vld"}, rd_dat_vld_o, 0);
    chk_eq({tag, "_last"}, rd_last_o, 0);
    chk_eq({tag, "_busy"}, busy_o, 0);
    chk_eq({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    do_run(1, 0, 5, 0);
    do_run(4, 0, 5, 0);
    do_run(3, 1, 5, 0);
    do_run(0, 0, 5, 0);
    do_run(3, 0, 280, 1);

    // Reset in the middle of the third sweep of a 5-LCU run.
    begin
      bit hit;
      hit = 0;
      start_run(5, 0, 5, 0);
      for (int c = 0; c < 2000 && !hit; c++) begin
        @(negedge clk);
        if (cnt_last == 2) hit = 1;
      end
      chk_eq("reach_third_sweep", hit, 1);
      repeat (30) @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      chk_all_zero("midrun_reset");
      exp_q.delete();
      rot_tot = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_all_zero("held_reset");
      @(posedge clk);
      #1 rstn = 1'b1;
      do_run(2, 1, 5, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end
endmodule
